multi_mode_timekeeper: RTL and testbench

Parametrised successor to the single-mode stopwatch/clock display block. It has three modes: free-running 24 h clock, clock setting, and stopwatch with lap hold and auto range switch. It takes pre-debounced key pulses and levels from key_stable instances and drives four BCD digits into the seven-segment decoders. Timing derives from CLK_HZ, so the same RTL runs on the 50 MHz board and in fast simulation.

---
 rtl/multi_mode_timekeeper.sv | 216 +++++++++++++++++++++
 tb/tb_multi_mode_timekeeper.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_mode_timekeeper.sv
// Three-mode timekeeper: free-running 24 h clock, clock setting, and a stopwatch
// with lap hold. Drives four BCD digits. All timing is derived from CLK_HZ.
module multi_mode_timekeeper #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int LONG_PRESS_MS = 4000,
    parameter int BLINK_HZ      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_a_press,
    input  logic        key_b_press,
    input  logic        key_a_level,
    input  logic        key_b_level,
    output logic [15:0] digits,
    output logic [1:0]  mode,
    output logic [1:0]  digit_sel,
    output logic [3:0]  blink_mask,
    output logic        colon,
    output logic        sw_running
);
    localparam int     CENTI_DIV  = CLK_HZ / 100;
    localparam longint LONG_CYC_L = longint'(LONG_PRESS_MS) * longint'(CLK_HZ) / 1000;
    localparam int     LONG_CYC   = int'(LONG_CYC_L);
    localparam int     BLINK_HALF = (50 / BLINK_HZ) > 0 ? (50 / BLINK_HZ) : 1;
    localparam int     DIV_W      = $clog2(CENTI_DIV);
    localparam int     LP_W       = $clog2(LONG_CYC + 1);
    localparam int     BL_W       = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {M_CLOCK = 2'd0, M_SET = 2'd1, M_SW = 2'd2} mode_t;

    mode_t            state;
    logic [1:0]       sel;
    logic [DIV_W-1:0] div_cnt;
    logic [6:0]       clk_cc;
    logic [BL_W-1:0]  bl_cnt;
    logic             bl_on, running, lap_on;
    logic [15:0]      lap_val;
    logic [3:0]       c_h1, c_h0, c_m1, c_m0, c_s1, c_s0;
    logic [3:0]       s_m1, s_m0, s_s1, s_s0, s_c1, s_c0;
    logic [LP_W-1:0]  la_cnt, lab_cnt;
    logic             long_lock, long_a, long_ab;

    logic        centi_tick, sec_tick, a_only, b_only, cond_a, cond_ab;
    logic [8:0]  cs_n, cm_n, ch_n, sc_n, ss_n, sm_n;
    logic [15:0] sw_live, clock_disp;

    // Returns {wrap, hi, lo} for a two-digit BCD counter whose low digit runs 0-9.
    function automatic logic [8:0] bcd_inc(input logic [3:0] hi, input logic [3:0] lo,
                                           input logic [3:0] hi_max);
        if (lo != 4'd9)      return {1'b0, hi, lo + 4'd1};
        else if (hi != hi_max) return {1'b0, hi + 4'd1, 4'd0};
        else                 return 9'h100;
    endfunction

    assign centi_tick = (div_cnt == DIV_W'(CENTI_DIV - 1));
    assign sec_tick   = centi_tick && (clk_cc == 7'd99) && (state != M_SET);
    assign a_only     = key_a_press & ~key_b_press;
    assign b_only     = key_b_press & ~key_a_press;
    assign cond_a     = key_a_level & ~key_b_level;
    assign cond_ab    = key_a_level & key_b_level;

    assign mode       = state;
    assign digit_sel  = sel;
    assign sw_running = running;

    always_comb begin
        cs_n = bcd_inc(c_s1, c_s0, 4'd5);
        cm_n = bcd_inc(c_m1, c_m0, 4'd5);
        ch_n = (c_h1 == 4'd2 && c_h0 == 4'd3) ? 9'h100 : bcd_inc(c_h1, c_h0, 4'd2);
        sc_n = bcd_inc(s_c1, s_c0, 4'd9);
        ss_n = bcd_inc(s_s1, s_s0, 4'd5);
        sm_n = bcd_inc(s_m1, s_m0, 4'd5);
        sw_live    = (s_m1 == 4'd0 && s_m0 == 4'd0) ? {s_s1, s_s0, s_c1, s_c0}
                                                    : {s_m1, s_m0, s_s1, s_s0};
        clock_disp = key_b_level ? {c_m1, c_m0, c_s1, c_s0} : {c_h1, c_h0, c_m1, c_m0};
    end

    // Long-press events are locked out after firing until both keys are released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            la_cnt    <= '0;
            lab_cnt   <= '0;
            long_lock <= 1'b0;
            long_a    <= 1'b0;
            long_ab   <= 1'b0;
        end else begin
            long_a  <= 1'b0;
            long_ab <= 1'b0;
            la_cnt  <= !cond_a  ? '0 : (la_cnt  == LP_W'(LONG_CYC)) ? la_cnt  : la_cnt  + 1'b1;
            lab_cnt <= !cond_ab ? '0 : (lab_cnt == LP_W'(LONG_CYC)) ? lab_cnt : lab_cnt + 1'b1;
            if (!key_a_level && !key_b_level) begin
                long_lock <= 1'b0;
            end else if (!long_lock && cond_a && la_cnt == LP_W'(LONG_CYC - 1)) begin
                long_a    <= 1'b1;
                long_lock <= 1'b1;
            end else if (!long_lock && cond_ab && lab_cnt == LP_W'(LONG_CYC - 1)) begin
                long_ab   <= 1'b1;
                long_lock <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= M_CLOCK;
            sel     <= 2'd0;
            div_cnt <= '0;
            clk_cc  <= '0;
            bl_cnt  <= '0;
            bl_on   <= 1'b0;
            running <= 1'b0;
            lap_on  <= 1'b0;
            lap_val <= '0;
            {c_h1, c_h0, c_m1, c_m0, c_s1, c_s0} <= '0;
            {s_m1, s_m0, s_s1, s_s0, s_c1, s_c0} <= '0;
        end else begin
            div_cnt <= centi_tick ? '0 : div_cnt + 1'b1;
            if (centi_tick) begin
                bl_cnt <= (bl_cnt == BL_W'(BLINK_HALF - 1)) ? '0 : bl_cnt + 1'b1;
                if (bl_cnt == BL_W'(BLINK_HALF - 1)) bl_on <= ~bl_on;
                if (state != M_SET) clk_cc <= (clk_cc == 7'd99) ? 7'd0 : clk_cc + 7'd1;
            end
            if (sec_tick) begin
                {c_s1, c_s0} <= cs_n[7:0];
                if (cs_n[8]) begin
                    {c_m1, c_m0} <= cm_n[7:0];
                    if (cm_n[8]) {c_h1, c_h0} <= ch_n[7:0];
                end
            end
            if (centi_tick && running) begin
                {s_c1, s_c0} <= sc_n[7:0];
                if (sc_n[8]) begin
                    {s_s1, s_s0} <= ss_n[7:0];
                    if (ss_n[8]) {s_m1, s_m0} <= sm_n[7:0];
                end
            end
            // NOTE: the last non-blocking assignment in a cycle wins, so the mode
            // actions below take priority over the free-running updates above.
            case (state)
                M_CLOCK: begin
                    if (long_ab) begin
                        state <= M_SW;
                    end else if (a_only) begin
                        state  <= M_SET;
                        sel    <= 2'd0;
                        bl_cnt <= '0;
                        bl_on  <= 1'b0;
                    end
                end
                M_SET: begin
                    if (long_a) begin
                        state   <= M_CLOCK;
                        {c_s1, c_s0} <= 8'h00;
                        div_cnt <= '0;
                        clk_cc  <= '0;
                    end else if (a_only) begin
                        sel <= sel + 2'd1;
                    end else if (b_only) begin
                        case (sel)
                            2'd0: c_m0 <= (c_m0 >= 4'd9) ? 4'd0 : c_m0 + 4'd1;
                            2'd1: c_m1 <= (c_m1 >= 4'd5) ? 4'd0 : c_m1 + 4'd1;
                            2'd2: c_h0 <= (c_h0 >= ((c_h1 == 4'd2) ? 4'd3 : 4'd9)) ? 4'd0
                                                                                   : c_h0 + 4'd1;
                            default: begin
                                c_h1 <= (c_h1 >= 4'd2) ? 4'd0 : c_h1 + 4'd1;
                                if (c_h1 == 4'd1 && c_h0 > 4'd3) c_h0 <= 4'd3;
                            end
                        endcase
                    end
                end
                M_SW: begin
                    if (long_ab) begin
                        state <= M_CLOCK;
                    end else if (b_only) begin
                        running <= ~running;
                    end else if (a_only) begin
                        if (running) begin
                            lap_on  <= ~lap_on;
                            lap_val <= sw_live;
                        end else begin
                            lap_on <= 1'b0;
                            {s_m1, s_m0, s_s1, s_s0, s_c1, s_c0} <= '0;
                        end
                    end
                end
                default: state <= M_CLOCK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits     <= '0;
            blink_mask <= '0;
            colon      <= 1'b0;
        end else begin
            case (state)
                M_SET: begin
                    digits     <= {c_h1, c_h0, c_m1, c_m0};
                    colon      <= 1'b1;
                    blink_mask <= bl_on ? (4'b0001 << sel) : 4'b0000;
                end
                M_SW: begin
                    digits     <= lap_on ? lap_val : sw_live;
                    colon      <= 1'b1;
                    blink_mask <= 4'b0000;
                end
                default: begin
                    digits     <= clock_disp;
                    colon      <= (clk_cc < 7'd50);
                    blink_mask <= 4'b0000;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multi_mode_timekeeper.sv
// Directed bench for multi_mode_timekeeper at CLK_HZ=200 (centi_tick every 2 cycles,
// LONG_CYC=20); expected values go through a scoreboard queue.
module tb_multi_mode_timekeeper;
    localparam int CLK_HZ        = 200;
    localparam int LONG_PRESS_MS = 100;
    localparam int BLINK_HZ      = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_a_press = 1'b0, key_b_press = 1'b0;
    logic        key_a_level = 1'b0, key_b_level = 1'b0;
    logic [15:0] digits;
    logic [1:0]  mode, digit_sel;
    logic [3:0]  blink_mask;
    logic        colon, sw_running;

    multi_mode_timekeeper #(
        .CLK_HZ(CLK_HZ), .LONG_PRESS_MS(LONG_PRESS_MS), .BLINK_HZ(BLINK_HZ)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .key_a_press(key_a_press), .key_b_press(key_b_press),
        .key_a_level(key_a_level), .key_b_level(key_b_level),
        .digits(digits), .mode(mode), .digit_sel(digit_sel),
        .blink_mask(blink_mask), .colon(colon), .sw_running(sw_running)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    task automatic sb_push(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [15:0] obs);
        exp_t e;
        n_asserts++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h, no expectation queued", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic a, input logic b);
        @(negedge clk);
        key_a_press = a;
        key_b_press = b;
        @(negedge clk);
        key_a_press = 1'b0;
        key_b_press = 1'b0;
    endtask

    task automatic hold_until_mode(input logic a, input logic b, input logic [1:0] m,
                                   output int lat);
        key_a_level = a;
        key_b_level = b;
        lat = 0;
        while (mode !== m && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [15:0] in_range(input int v, input int lo, input int hi);
        return (v >= lo && v <= hi) ? 16'd1 : 16'd0;
    endfunction

    initial begin
        int lat, t, on_cnt, off_cnt, bad_cnt;

        // Reset state
        tick(3);
        sb_push("rst_digits", 16'h0000);  sb_check(digits);
        sb_push("rst_mode", 16'd0);       sb_check({14'b0, mode});
        sb_push("rst_blink", 16'd0);      sb_check({12'b0, blink_mask});
        rst_n = 1'b1;
        tick(3);
        sb_push("post_rst_digits", 16'h0000); sb_check(digits);
        sb_push("post_rst_sel", 16'd0);       sb_check({14'b0, digit_sel});

        // SET mode: hour units to 9, then tens to 2 clamps units to 3
        press(1, 0); tick(1);
        sb_push("enter_set_mode", 16'd1); sb_check({14'b0, mode});
        press(1, 0); press(1, 0);
        sb_push("sel_hour_units", 16'd2); sb_check({14'b0, digit_sel});
        repeat (9) press(0, 1);
        tick(1);
        sb_push("hour_units_9", 16'h0900); sb_check(digits);
        press(1, 0);
        repeat (2) press(0, 1);
        tick(1);
        sb_push("hour_tens_clamp", 16'h2300); sb_check(digits);
        press(1, 0);
        sb_push("sel_wrap", 16'd0); sb_check({14'b0, digit_sel});
        repeat (9) press(0, 1);
        press(1, 0);
        repeat (5) press(0, 1);
        tick(1);
        sb_push("set_2359", 16'h2359); sb_check(digits);

        on_cnt = 0; off_cnt = 0; bad_cnt = 0;
        repeat (120) begin
            @(negedge clk);
            if (blink_mask === 4'b0010)      on_cnt++;
            else if (blink_mask === 4'b0000) off_cnt++;
            else                             bad_cnt++;
        end
        sb_push("blink_on_seen", 16'd1);   sb_check((on_cnt > 0) ? 16'd1 : 16'd0);
        sb_push("blink_off_seen", 16'd1);  sb_check((off_cnt > 0) ? 16'd1 : 16'd0);
        sb_push("blink_other_bits", 16'd0); sb_check(16'(bad_cnt));
        sb_push("set_colon", 16'd1);       sb_check({15'b0, colon});

        hold_until_mode(1, 0, 2'd0, lat);
        key_a_level = 1'b0;
        sb_push("long_a_exit", 16'd0);     sb_check({14'b0, mode});
        sb_push("long_a_latency", 16'd1);  sb_check(in_range(lat, 19, 24));

        // Clock: MM:SS view mid-minute, then wrap 23:59:59 -> 00:00:00
        tick(6100);
        key_b_level = 1'b1;
        tick(2);
        sb_push("mmss_view", 16'h5930);    sb_check(digits);
        key_b_level = 1'b0;
        tick(2);
        sb_push("hhmm_view", 16'h2359);    sb_check(digits);
        t = 6104;
        while (digits === 16'h2359 && t < 12200) begin
            @(negedge clk);
            t++;
        end
        sb_push("clock_wrap", 16'h0000);   sb_check(digits);
        sb_push("wrap_time", 16'd1);       sb_check(in_range(t, 11995, 12005));
        key_b_level = 1'b1;
        tick(2);
        sb_push("wrap_mmss", 16'h0000);    sb_check(digits);

        t = 0;
        while (colon !== 1'b0 && t < 300) begin @(negedge clk); t++; end
        t = 0;
        while (colon !== 1'b1 && t < 300) begin @(negedge clk); t++; end
        tick(50);
        sb_push("colon_first_half", 16'd1);  sb_check({15'b0, colon});
        tick(100);
        sb_push("colon_second_half", 16'd0); sb_check({15'b0, colon});
        tick(100);
        sb_push("colon_next_second", 16'd1); sb_check({15'b0, colon});
        key_b_level = 1'b0;

        // Stopwatch range switch
        hold_until_mode(1, 1, 2'd2, lat);
        key_a_level = 1'b0; key_b_level = 1'b0;
        sb_push("enter_stopwatch", 16'd2); sb_check({14'b0, mode});
        sb_push("long_ab_latency", 16'd1); sb_check(in_range(lat, 19, 24));
        tick(2);
        press(0, 1);
        sb_push("sw_start", 16'd1);        sb_check({15'b0, sw_running});
        t = 0;
        while (digits !== 16'h0001 && t < 20) begin @(negedge clk); t++; end
        sb_push("sw_first_centi", 16'h0001); sb_check(digits);
        tick(2000);
        sb_push("sw_10_01", 16'h1001);     sb_check(digits);
        tick(9996);
        sb_push("sw_59_99", 16'h5999);     sb_check(digits);
        tick(2);
        sb_push("sw_range_switch", 16'h0100); sb_check(digits);

        // Lap hold, release, stop and clear
        press(1, 0);
        tick(1);
        sb_push("lap_hold_0", 16'h0100);   sb_check(digits);
        tick(100);
        sb_push("lap_hold_100", 16'h0100); sb_check(digits);
        tick(200);
        sb_push("lap_hold_300", 16'h0100); sb_check(digits);
        sb_push("lap_still_running", 16'd1); sb_check({15'b0, sw_running});
        press(1, 0);
        tick(1);
        sb_push("lap_release_live", 16'h0101); sb_check(digits);
        press(0, 1);
        tick(1);
        sb_push("sw_stop", 16'd0);         sb_check({15'b0, sw_running});
        press(1, 0);
        tick(1);
        sb_push("sw_clear", 16'h0000);     sb_check(digits);
        tick(50);
        sb_push("sw_clear_stays", 16'h0000); sb_check(digits);

        // Back to clock; simultaneous presses; single long_ab firing
        hold_until_mode(1, 1, 2'd0, lat);
        key_a_level = 1'b0; key_b_level = 1'b0;
        sb_push("sw_exit", 16'd0);         sb_check({14'b0, mode});
        tick(2);
        sb_push("clock_kept_running", 16'h0001); sb_check(digits);
        press(1, 1);
        tick(2);
        sb_push("simul_press_ignored", 16'd0); sb_check({14'b0, mode});
        hold_until_mode(1, 1, 2'd2, lat);
        sb_push("long_ab_fire", 16'd2);    sb_check({14'b0, mode});
        sb_push("long_ab_fire_lat", 16'd1); sb_check(in_range(lat, 19, 24));
        tick(80);
        sb_push("no_refire", 16'd2);       sb_check({14'b0, mode});
        key_a_level = 1'b0; key_b_level = 1'b0;
        tick(2);
        hold_until_mode(1, 1, 2'd0, lat);
        key_a_level = 1'b0; key_b_level = 1'b0;
        sb_push("rearm_after_release", 16'd0); sb_check({14'b0, mode});

        // Reset in the middle of a running stopwatch
        tick(2);
        hold_until_mode(1, 1, 2'd2, lat);
        key_a_level = 1'b0; key_b_level = 1'b0;
        tick(2);
        press(0, 1);
        tick(5);
        sb_push("pre_reset_running", 16'd1); sb_check({15'b0, sw_running});
        rst_n = 1'b0;
        tick(1);
        sb_push("mid_rst_digits", 16'h0000); sb_check(digits);
        sb_push("mid_rst_mode", 16'd0);      sb_check({14'b0, mode});
        sb_push("mid_rst_running", 16'd0);   sb_check({15'b0, sw_running});
        sb_push("mid_rst_blink", 16'd0);     sb_check({12'b0, blink_mask});
        sb_push("mid_rst_colon", 16'd0);     sb_check({15'b0, colon});
        tick(2);
        rst_n = 1'b1;
        tick(2);
        sb_push("after_rst_digits", 16'h0000); sb_check(digits);
        sb_push("after_rst_running", 16'd0);   sb_check({15'b0, sw_running});

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
